// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, state type and signed-limit helpers for the adder result path
//
// Purpose: default widths, the result-stage occupancy state and functions that
// build the signed max/min patterns for an arbitrary data width.
// Ports: none (package).

package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

    // Occupancy of the two-entry output stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // main register valid
        TWO   = 2'd2    // main and skid registers valid
    } stage_state_e;

    // Largest positive two's-complement value of width w (0111...1),
    // returned right-aligned in 64 bits; callers cast to their width.
    function automatic logic [63:0] signed_max(input int w);
        signed_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width w (1000...0).
    function automatic logic [63:0] signed_min(input int w);
        signed_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear priority
//
// Purpose: counts single-cycle increment strobes, sticks at all-ones, and
// returns to zero on clear. A clear in the same cycle as an increment wins.
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset, count goes to 0
//   inc_i    in   count one event this cycle
//   clr_i    in   synchronous clear (priority over inc_i)
//   count_o  out  current count, CNT_W bits

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/adder_result_stage.sv
// rtl/adder_result_stage.sv - registered two-entry elastic output stage for adder results
//
// Purpose: captures sum/carry/overflow from the ripple adder on a valid/ready
// handshake and presents them from a main register backed by a skid register,
// so the stage sustains one beat per cycle while keeping InReady free of any
// combinational path from OutReady. Counts overflowed beats delivered
// downstream in a saturating counter.
// Optional feature: define SATURATE_EN to clamp the stored sum on signed
// overflow (wrapped negative -> max positive, wrapped positive -> min negative).
// Without SATURATE_EN the sum is stored unchanged.
// Ports:
//   Clk            in   clock
//   Rst            in   asynchronous active-high reset
//   InValid        in   upstream result valid
//   InReady        out  stage can accept a beat (low only when both entries full)
//   InSum          in   adder sum, WIDTH bits
//   InCarry        in   adder carry-out
//   InOverFlow     in   adder signed overflow
//   OutValid       out  registered result valid
//   OutReady       in   downstream accepts
//   OutSum         out  registered (optionally clamped) sum
//   OutCarry       out  registered carry
//   OutOverFlow    out  registered overflow flag
//   CountClear     in   synchronous clear of OverFlowCount
//   OverFlowCount  out  overflowed beats transferred at the output, CNT_W bits

module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InSum,
    input  logic             InCarry,
    input  logic             InOverFlow,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutSum,
    output logic             OutCarry,
    output logic             OutOverFlow,
    input  logic             CountClear,
    output logic [CNT_W-1:0] OverFlowCount
);

    stage_state_e state_q;
    stage_state_e state_d;

    logic             in_ready;
    logic             out_valid;
    logic             in_xfer;
    logic             out_xfer;

    logic             load_main_in;    // main <- incoming beat
    logic             load_main_skid;  // main <- skid entry
    logic             load_skid;       // skid <- incoming beat

    logic [WIDTH-1:0] cap_sum;

    logic [WIDTH-1:0] main_sum_q;
    logic             main_carry_q;
    logic             main_ovf_q;
    logic [WIDTH-1:0] skid_sum_q;
    logic             skid_carry_q;
    logic             skid_ovf_q;

    // Handshake flags decode registered state only.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = InValid && in_ready;
    assign out_xfer  = out_valid && OutReady;

`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] SUM_MAX = WIDTH'(signed_max(WIDTH));
    localparam logic [WIDTH-1:0] SUM_MIN = WIDTH'(signed_min(WIDTH));

    // An overflowed sum has the wrong sign: a set MSB means the true result
    // was too large positive, a clear MSB means it was too large negative.
    always_comb begin
        cap_sum = InSum;
        if (InOverFlow) begin
            cap_sum = InSum[WIDTH-1] ? SUM_MAX : SUM_MIN;
        end
    end
`else
    assign cap_sum = InSum;
`endif

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d = TWO;
                end else if (!in_xfer && out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath load strobes
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                load_main_in = in_xfer;
            end
            ONE: begin
                // Main is draining this cycle: the new beat replaces it.
                // Otherwise main is stalled and the beat parks in skid.
                if (in_xfer) begin
                    if (out_xfer) begin
                        load_main_in = 1'b1;
                    end else begin
                        load_skid = 1'b1;
                    end
                end
            end
            TWO: begin
                load_main_skid = out_xfer;
            end
            default: begin
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_sum_q   <= '0;
            main_carry_q <= 1'b0;
            main_ovf_q   <= 1'b0;
            skid_sum_q   <= '0;
            skid_carry_q <= 1'b0;
            skid_ovf_q   <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_sum_q   <= cap_sum;
                main_carry_q <= InCarry;
                main_ovf_q   <= InOverFlow;
            end else if (load_main_skid) begin
                main_sum_q   <= skid_sum_q;
                main_carry_q <= skid_carry_q;
                main_ovf_q   <= skid_ovf_q;
            end
            if (load_skid) begin
                skid_sum_q   <= cap_sum;
                skid_carry_q <= InCarry;
                skid_ovf_q   <= InOverFlow;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_ovf_count (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .inc_i   (out_xfer && main_ovf_q),
        .clr_i   (CountClear),
        .count_o (OverFlowCount)
    );

    assign InReady     = in_ready;
    assign OutValid    = out_valid;
    assign OutSum      = main_sum_q;
    assign OutCarry    = main_carry_q;
    assign OutOverFlow = main_ovf_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// tb/tb_adder_result_stage.sv - self-checking bench for adder_result_stage

module tb_adder_result_stage;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          InValid;
    logic          InReady;
    logic [W-1:0]  InSum;
    logic          InCarry;
    logic          InOverFlow;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  OutSum;
    logic          OutCarry;
    logic          OutOverFlow;
    logic          CountClear;
    logic [CW-1:0] OverFlowCount;

    always #5 Clk = ~Clk;

    adder_result_stage #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .InValid       (InValid),
        .InReady       (InReady),
        .InSum         (InSum),
        .InCarry       (InCarry),
        .InOverFlow    (InOverFlow),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .OutSum        (OutSum),
        .OutCarry      (OutCarry),
        .OutOverFlow   (OutOverFlow),
        .CountClear    (CountClear),
        .OverFlowCount (OverFlowCount)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats plus a saturating counter.
    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
    } beat_t;

    beat_t        mq[$];
    int           mcnt  = 0;
    int           n_in  = 0;
    int           n_out = 0;
    logic [W-1:0] out_log[$];
    bit           ox;
    bit           ix;

    function automatic logic [W-1:0] expect_sum(input logic [W-1:0] s, input logic o);
`ifdef SATURATE_EN
        if (o) return s[W-1] ? 16'h7FFF : 16'h8000;
`endif
        return s;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            ox = (mq.size() > 0) && OutReady;
            ix = InValid && (mq.size() < 2);
            if (CountClear) mcnt = 0;
            else if (ox && mq[0].o && mcnt < 255) mcnt++;
            if (ox) begin
                void'(mq.pop_front());
                n_out++;
            end
            if (ix) begin
                mq.push_back('{sum: expect_sum(InSum, InOverFlow), c: InCarry, o: InOverFlow});
                n_in++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (!Rst) begin
            chk("out_valid", OutValid, mq.size() > 0);
            chk("in_ready", InReady, mq.size() < 2);
            chk("ovf_count", OverFlowCount, mcnt);
            if (mq.size() > 0) begin
                chk("out_sum", OutSum, mq[0].sum);
                chk("out_carry", OutCarry, mq[0].c);
                chk("out_ovf", OutOverFlow, mq[0].o);
            end
            if (OutValid && OutReady) out_log.push_back(OutSum);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [W-1:0] lit_sat_neg;
    logic [W-1:0] lit_sat_pos;
    int           sent;
    int           cyc;
    int           out0;

    initial begin
`ifdef SATURATE_EN
        lit_sat_neg = 16'h7FFF;
        lit_sat_pos = 16'h8000;
`else
        lit_sat_neg = 16'h8001;
        lit_sat_pos = 16'h7FF0;
`endif
        Rst = 1'b1; InValid = 1'b0; InSum = '0; InCarry = 1'b0; InOverFlow = 1'b0;
        OutReady = 1'b0; CountClear = 1'b0;
        step(); step();
        chk("rst_out_valid", OutValid, 0);
        chk("rst_in_ready", InReady, 1);
        chk("rst_out_sum", OutSum, 0);
        chk("rst_out_carry", OutCarry, 0);
        chk("rst_out_ovf", OutOverFlow, 0);
        chk("rst_count", OverFlowCount, 0);
        Rst = 1'b0;
        step();

        // Streaming with OutReady held high.
        OutReady = 1'b1;
        out_log.delete();
        for (int i = 1; i <= 16; i++) begin
            InValid = 1'b1; InSum = W'(i); InCarry = i[0]; InOverFlow = 1'b0;
            step();
            if (i == 1) begin
                chk("latency_valid", OutValid, 1);
                chk("latency_sum", OutSum, 16'h0001);
            end
        end
        InValid = 1'b0;
        step(); step();
        chk("stream_count", out_log.size(), 16);
        for (int k = 0; k < 16 && k < out_log.size(); k++) chk("stream_order", out_log[k], k + 1);

        // Backpressure fills both entries.
        OutReady = 1'b0;
        InValid = 1'b1; InSum = 16'h1111; InCarry = 1'b0;
        step();
        InSum = 16'h2222;
        step();
        InValid = 1'b0;
        chk("two_in_ready", InReady, 0);
        chk("two_head", OutSum, 16'h1111);
        out_log.delete();
        OutReady = 1'b1;
        step();
        chk("drain_second", OutSum, 16'h2222);
        chk("drain_in_ready", InReady, 1);
        step();
        chk("drain_empty", OutValid, 0);
        chk("drain_log_size", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("drain_log0", out_log[0], 16'h1111);
            chk("drain_log1", out_log[1], 16'h2222);
        end

        // Overflow capture (clamped only when saturation is built in).
        InValid = 1'b1; InSum = 16'h8001; InOverFlow = 1'b1; InCarry = 1'b1;
        step();
        InSum = 16'h7FF0; InCarry = 1'b0;
        chk("sat_neg_sum", OutSum, lit_sat_neg);
        chk("sat_neg_ovf", OutOverFlow, 1);
        chk("sat_neg_carry", OutCarry, 1);
        step();
        InValid = 1'b0; InOverFlow = 1'b0;
        chk("sat_pos_sum", OutSum, lit_sat_pos);
        chk("sat_pos_ovf", OutOverFlow, 1);
        step();
        chk("count_two", OverFlowCount, 2);

        // Counter saturation and clear priority.
        for (int i = 0; i < 260; i++) begin
            InValid = 1'b1; InOverFlow = 1'b1; InSum = W'($urandom);
            step();
        end
        InValid = 1'b0; InOverFlow = 1'b0;
        step(); step();
        chk("count_saturated", OverFlowCount, 8'hFF);
        InValid = 1'b1; InOverFlow = 1'b1; InSum = 16'h1234;
        step();
        InValid = 1'b0; InOverFlow = 1'b0; CountClear = 1'b1;
        step();
        CountClear = 1'b0;
        chk("count_clear_priority", OverFlowCount, 0);
        chk("clear_beat_gone", OutValid, 0);

        // Asynchronous reset while holding two entries.
        InValid = 1'b1; InOverFlow = 1'b1; InSum = 16'h0F0F;
        step();
        InValid = 1'b0; InOverFlow = 1'b0;
        step();
        chk("pre_reset_count", OverFlowCount, 1);
        OutReady = 1'b0;
        InValid = 1'b1; InSum = 16'h5555;
        step();
        InSum = 16'h6666;
        step();
        InValid = 1'b0;
        chk("pre_reset_full", InReady, 0);
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst_valid", OutValid, 0);
        chk("async_rst_ready", InReady, 1);
        chk("async_rst_count", OverFlowCount, 0);
        step();
        Rst = 1'b0;
        OutReady = 1'b1;
        InValid = 1'b1; InSum = 16'hABCD; InCarry = 1'b0;
        step();
        InValid = 1'b0;
        chk("post_rst_valid", OutValid, 1);
        chk("post_rst_sum", OutSum, 16'hABCD);
        step();
        chk("post_rst_empty", OutValid, 0);

        // Random handshakes, 10k beats.
        sent = 0; cyc = 0; out0 = n_out;
        while (sent < 10000 && cyc < 60000) begin
            InValid    = ($urandom_range(0, 3) != 0);
            OutReady   = ($urandom_range(0, 3) != 0);
            InSum      = W'($urandom);
            InCarry    = 1'($urandom);
            InOverFlow = ($urandom_range(0, 7) == 0);
            CountClear = ($urandom_range(0, 999) == 0);
            if (InValid && mq.size() < 2) sent++;
            step();
            cyc++;
        end
        InValid = 1'b0; OutReady = 1'b1; CountClear = 1'b0;
        step(); step(); step();
        chk("random_sent", sent, 10000);
        chk("random_delivered", n_out - out0, 10000);
        chk("random_empty", OutValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
